reduce_sequencer: RTL
=====================

Name: reduce_sequencer

Overview:
- Multi-cycle controller that time-shares one 8-bit reduction unit (bitwise_reduce: AND/OR/XOR) across a DATA_W-bit input word.
- Accepts a word over a valid/ready handshake and feeds it to the unit one byte per cycle, LSB byte first.
- Accumulates partial AND/OR/XOR results and presents full-word reductions over a valid/ready output handshake.
- Sits between a wide producer and the shared narrow reduction datapath.

Parameters:
- DATA_W, 32, input word width; multiple of 8, minimum 8.
- CNT_W, 16, width of performance counters; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  word to reduce.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- out_and  output  1  AND-reduction of the accepted word.
- out_or  output  1  OR-reduction of the accepted word.
- out_xor  output  1  XOR-reduction of the accepted word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Derived constant: NCHUNK = DATA_W/8.
- Reset: state IDLE; out_valid, out_and, out_or, out_xor, busy = 0; accumulators cleared; shift register and chunk index = 0.
- in_ready is a decode of state == IDLE, so it reads 1 during reset. No capture occurs while rst is high.
- IDLE: in_ready = 1.
  - On in_valid && in_ready, capture in_data into the shift register.
  - Set acc_and = 1, acc_or = 0, acc_xor = 0, idx = 0; go to RUN.
- RUN: in_ready = 0.
  - Each cycle, drive shift register bits [7:0] to the reduce unit.
  - acc_and &= red_and; acc_or |= red_or; acc_xor ^= red_xor.
  - Shift right by 8; idx++.
  - On the cycle with idx == NCHUNK-1, register the final accumulated values into out_* and go to DONE.
- DONE: out_valid = 1; out_* held stable while out_ready = 0.
  - On out_ready, clear out_valid and go to IDLE.
  - out_* keep their last values after the handshake; they are don't-care while out_valid = 0.
- Latency: out_valid rises exactly NCHUNK rising edges after the accepting edge.
- Minimum accept-to-accept period: NCHUNK+2 edges. There is no overlap of a new input with a pending output.
- DATA_W == 8: RUN lasts exactly 1 cycle.
- in_valid while not IDLE: ignored; in_data need not be held after acceptance.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes; the input is accepted in IDLE on the next edge.
- Reset mid-operation (RUN or DONE): immediate abort, results discarded, out_valid drops asynchronously, state returns to IDLE.
- The reduce unit is purely combinational; its inputs are driven only from the registered shift register (no combinational path from in_data).

Optional Feature:
- Macro: REDUCE_SEQ_PERF_EN.
- When defined, adds two outputs:
  - perf_words [CNT_W]: increments on each output handshake.
  - perf_busy [CNT_W]: increments on each cycle spent in RUN.
  - Both saturate at all-ones, reset to 0, and are cleared only by rst.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package reduce_seq_pkg contains:
  - localparam CHUNK_W = 8.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} reduce_seq_state_t.
  - function nchunk(DATA_W).
- Natural sub-module: one instance of the existing bitwise_reduce unit as the datapath.
- FSM, accumulators and shift register stay in reduce_sequencer.

Test Plan:
- DATA_W=32, in_data=0xFFFFFFFF -> out_and=1, out_or=1, out_xor=0; out_valid rises 4 edges after acceptance.
- in_data=0x00000001 -> and=0, or=1, xor=1. in_data=0x00000000 -> and=0, or=0, xor=0. in_data=0x01010100 -> and=0, or=1, xor=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with 0xFFFFFFFF -> out_* stable, in_ready=0, new word not captured; prior result delivered on out_ready.
- Assert rst during the 2nd RUN cycle -> out_valid=0 and busy=0 immediately. Next word 0x80000000 -> and=0, or=1, xor=1.
- DATA_W=8 build, in_data=0xA5 -> and=0, or=1, xor=0; out_valid 1 edge after acceptance.
- REDUCE_SEQ_PERF_EN, DATA_W=32: 3 words with out_ready tied 1 -> perf_words=3, perf_busy=12.

Source files
------------

// File: rtl/reduce_seq_pkg.sv
// Shared types and constants for the byte-serial reduce sequencer.
// Optional performance counters are enabled with REDUCE_SEQ_PERF_EN.
package reduce_seq_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } reduce_seq_state_t;

  function automatic int nchunk(input int data_w);
    return data_w / CHUNK_W;
  endfunction

endpackage

// File: rtl/reduce_sequencer_reduce.sv
// Shared narrow datapath: combinational AND/OR/XOR reduction of one chunk.
// Holds no state; it is time-shared by reduce_sequencer.
module bitwise_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  output logic         red_and,
  output logic         red_or,
  output logic         red_xor
);

  assign red_and = &data;
  assign red_or  = |data;
  assign red_xor = ^data;

endmodule

// File: rtl/reduce_sequencer.sv
// Feeds a wide word through one 8-bit reducer, LSB byte first.
// Define REDUCE_SEQ_PERF_EN to add perf_words/perf_busy counters.
module reduce_sequencer
  import reduce_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_and,
  output logic              out_or,
  output logic              out_xor,
  output logic              busy
`ifdef REDUCE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_words,
  output logic [CNT_W-1:0]  perf_busy
`endif
);

  localparam int NCHUNK = nchunk(DATA_W);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  reduce_seq_state_t state;

  logic [DATA_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;
  logic              acc_and;
  logic              acc_or;
  logic              acc_xor;
  logic              red_and;
  logic              red_or;
  logic              red_xor;

  // Reducer sees only the registered shift register, never in_data.
  bitwise_reduce #(
    .W(CHUNK_W)
  ) u_reduce (
    .data    (sreg[CHUNK_W-1:0]),
    .red_and (red_and),
    .red_or  (red_or),
    .red_xor (red_xor)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      acc_and   <= 1'b0;
      acc_or    <= 1'b0;
      acc_xor   <= 1'b0;
      out_valid <= 1'b0;
      out_and   <= 1'b0;
      out_or    <= 1'b0;
      out_xor   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= in_data;
            acc_and <= 1'b1;
            acc_or  <= 1'b0;
            acc_xor <= 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc_and <= acc_and & red_and;
          acc_or  <= acc_or | red_or;
          acc_xor <= acc_xor ^ red_xor;
          sreg    <= sreg >> CHUNK_W;
          idx     <= idx + IDX_W'(1);
          if (idx == LAST) begin
            out_and   <= acc_and & red_and;
            out_or    <= acc_or | red_or;
            out_xor   <= acc_xor ^ red_xor;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef REDUCE_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_words <= '0;
      perf_busy  <= '0;
    end else begin
      if (state == DONE && out_ready && perf_words != '1)
        perf_words <= perf_words + CNT_W'(1);
      if (state == RUN && perf_busy != '1)
        perf_busy <= perf_busy + CNT_W'(1);
    end
  end
`endif

endmodule
